// File: rtl/sseg_pkg.sv
// Shared types and constants for the four-digit seven-segment scanner.
package sseg_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [7:0] DEF_LO_ID = 8'h81;
    localparam logic [7:0] DEF_HI_ID = 8'h82;

    localparam int BIN_W = 16;
    localparam int BCD_W = 20;

    // Active-low segment patterns, bit 0 = a ... bit 6 = g
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, restartable at any time.
module bin2bcd_seq
    import sseg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd_out
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t           state;
    logic [BIN_W-1:0] bin_q;
    logic [BCD_W-1:0] bcd_q;
    logic [BCD_W-1:0] bcd_adj;
    logic [CNT_W-1:0] cnt;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // A start in any state wins: it restarts the conversion and suppresses done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt     <= '0;
            bcd_out <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                bin_q <= bin_in;
                bcd_q <= '0;
                cnt   <= CNT_W'(BIN_W);
                state <= SHIFT;
                busy  <= 1'b1;
            end else begin
                case (state)
                    IDLE: ;
                    SHIFT: begin
                        {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
                        cnt            <= cnt - 1'b1;
                        if (cnt == CNT_W'(1))
                            state <= DONE;
                    end
                    DONE: begin
                        bcd_out <= bcd_q;
                        done    <= 1'b1;
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/sseg_scanner.sv
// MCU-port driven 4-digit decimal display with multiplexed scan.
// Define SSEG_BLANK_EN to blank leading zeros on digits 3..1.
module sseg_scanner
    import sseg_pkg::*;
#(
    parameter int         REFRESH_DIV = 50000,
    parameter logic [7:0] LO_ID       = DEF_LO_ID,
    parameter logic [7:0] HI_ID       = DEF_HI_ID
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       IO_STRB,
    input  logic [7:0] PORT_ID,
    input  logic [7:0] OUT_PORT,
    output logic [6:0] SEG,
    output logic [3:0] an,
    output logic       BUSY
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [7:0]       lo_q;
    logic             commit;
    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd;
    logic [BCD_W-1:0] disp_q;
    logic [RW-1:0]    ref_cnt;
    logic [1:0]       dig_idx;
    logic [3:0]       nib;
    logic             overflow;

    assign commit = IO_STRB && (PORT_ID == HI_ID);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            lo_q <= '0;
        else if (IO_STRB && (PORT_ID == LO_ID))
            lo_q <= OUT_PORT;
    end

    bin2bcd_seq u_conv (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .start   (commit),
        .bin_in  ({OUT_PORT, lo_q}),
        .busy    (BUSY),
        .done    (conv_done),
        .bcd_out (conv_bcd)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            disp_q <= '0;
        else if (conv_done)
            disp_q <= conv_bcd;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ref_cnt <= '0;
            dig_idx <= '0;
        end else if (ref_cnt == RW'(REFRESH_DIV - 1)) begin
            ref_cnt <= '0;
            dig_idx <= dig_idx + 2'd1;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

    assign nib      = disp_q[{dig_idx, 2'b00} +: 4];
    assign overflow = |disp_q[BCD_W-1:16];

`ifdef SSEG_BLANK_EN
    // lead_zero[i]: digit i and every digit to its left are zero.
    logic [3:0] lead_zero;
    assign lead_zero[3] = (disp_q[15:12] == 4'd0);
    assign lead_zero[2] = lead_zero[3] && (disp_q[11:8] == 4'd0);
    assign lead_zero[1] = lead_zero[2] && (disp_q[7:4] == 4'd0);
    assign lead_zero[0] = 1'b0;
`endif

    always_comb begin
        an = ~(4'b0001 << dig_idx);
        if (overflow)
            SEG = SEG_DASH;
        else
            SEG = seg_of(nib);
`ifdef SSEG_BLANK_EN
        if (!overflow && lead_zero[dig_idx])
            SEG = SEG_BLANK;
`endif
    end

endmodule

// File: tb/tb_sseg_scanner.sv
// Randomized and directed checks of sseg_scanner against a decimal-arithmetic reference model.
module tb_sseg_scanner;

    localparam int DIV = 4;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       IO_STRB = 1'b0;
    logic [7:0] PORT_ID = '0;
    logic [7:0] OUT_PORT = '0;
    logic [6:0] SEG;
    logic [3:0] an;
    logic       BUSY;

    int errors = 0;
    int checks = 0;

    // Reference model: shown value, pending commit and its countdown, scan time
    int         m_disp, m_pval, m_pend, m_busy, m_cyc;
    logic [7:0] m_lo;

    logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int         pw  [4]  = '{1, 10, 100, 1000};

    sseg_scanner #(.REFRESH_DIV(DIV), .LO_ID(8'h81), .HI_ID(8'h82)) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .IO_STRB  (IO_STRB),
        .PORT_ID  (PORT_ID),
        .OUT_PORT (OUT_PORT),
        .SEG      (SEG),
        .an       (an),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    function automatic int e_idx();
        return (m_cyc / DIV) % 4;
    endfunction

    function automatic logic [3:0] e_an();
        logic [3:0] one = 4'b0001;
        return ~(one << e_idx());
    endfunction

    function automatic logic [6:0] e_seg();
        int i = e_idx();
        if (m_disp > 9999) return 7'h3F;
`ifdef SSEG_BLANK_EN
        if (i > 0 && m_disp < pw[i]) return 7'h7F;
`endif
        return pat[(m_disp / pw[i]) % 10];
    endfunction

    function automatic logic e_busy();
        return m_busy > 0;
    endfunction

    task automatic model_reset();
        m_disp = 0; m_pval = 0; m_pend = 0; m_busy = 0; m_cyc = 0; m_lo = '0;
    endtask

    // Advance the model for the coming edge, then step past that edge.
    task automatic tick();
        m_cyc++;
        if (m_pend > 0) begin
            m_pend--;
            if (m_pend == 0) m_disp = m_pval;
        end
        if (m_busy > 0) m_busy--;
        if (IO_STRB && PORT_ID == 8'h82) begin
            m_pval = {OUT_PORT, m_lo};
            m_pend = 18;
            m_busy = 17;
        end
        if (IO_STRB && PORT_ID == 8'h81) m_lo = OUT_PORT;
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [7:0] id, input logic [7:0] d);
        IO_STRB = 1'b1; PORT_ID = id; OUT_PORT = d;
        tick();
        IO_STRB = 1'b0; PORT_ID = '0; OUT_PORT = '0;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        model_reset();
        #2;
        checks++;
        if (an !== 4'b1110) begin errors++; $display("FAIL reset_an got %b want 1110", an); end
        checks++;
        if (SEG !== 7'b1000000) begin errors++; $display("FAIL reset_seg got %b want 1000000", SEG); end
        checks++;
        if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", BUSY); end
        @(posedge CLK); @(posedge CLK); #1;
        RESET_N = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if ({SEG, an, BUSY} !== {e_seg(), e_an(), e_busy()}) begin
                errors++;
                $display("FAIL reset_scan cyc %0d got %b/%b/%b want %b/%b/%b", i, SEG, an, BUSY, e_seg(), e_an(), e_busy());
            end
        end
    endtask

    task automatic test_1234();
        int nbusy;
        wr(8'h81, 8'hD2);
        wr(8'h82, 8'h04);
        nbusy = (BUSY === 1'b1) ? 1 : 0;
        for (int i = 0; i < 19; i++) begin
            tick();
            if (BUSY === 1'b1) nbusy++;
            checks++;
            if ({SEG, an, BUSY} !== {e_seg(), e_an(), e_busy()}) begin
                errors++;
                $display("FAIL conv1234 cyc %0d got %b/%b/%b want %b/%b/%b", i, SEG, an, BUSY, e_seg(), e_an(), e_busy());
            end
        end
        checks++;
        if (nbusy != 17) begin errors++; $display("FAIL busy_len got %0d want 17", nbusy); end
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if ({SEG, an} !== {pat[(1234 / pw[e_idx()]) % 10], e_an()}) begin
                errors++;
                $display("FAIL show1234 cyc %0d got %b/%b want %b/%b", i, SEG, an, pat[(1234 / pw[e_idx()]) % 10], e_an());
            end
        end
    endtask

    task automatic test_overflow();
        wr(8'h81, 8'hFF);
        wr(8'h82, 8'hFF);
        for (int i = 0; i < 36; i++) begin
            tick();
            checks++;
            if ({SEG, an, BUSY} !== {e_seg(), e_an(), e_busy()}) begin
                errors++;
                $display("FAIL overflow cyc %0d got %b/%b/%b want %b/%b/%b", i, SEG, an, BUSY, e_seg(), e_an(), e_busy());
            end
        end
        checks++;
        if (SEG !== 7'b0111111) begin errors++; $display("FAIL dash got %b want 0111111", SEG); end
    endtask

    task automatic test_restart();
        wr(8'h81, 8'hD2);
        wr(8'h82, 8'h04);
        for (int i = 0; i < 4; i++) tick();
        wr(8'h81, 8'h07);
        wr(8'h82, 8'h00);
        for (int i = 0; i < 36; i++) begin
            tick();
            checks++;
            if ({SEG, an, BUSY} !== {e_seg(), e_an(), e_busy()}) begin
                errors++;
                $display("FAIL restart cyc %0d got %b/%b/%b want %b/%b/%b", i, SEG, an, BUSY, e_seg(), e_an(), e_busy());
            end
        end
    endtask

    task automatic test_reset_mid();
        wr(8'h81, 8'h0F);
        wr(8'h82, 8'h27);
        for (int i = 0; i < 8; i++) tick();
        RESET_N = 1'b0;
        model_reset();
        #2;
        checks++;
        if ({SEG, an, BUSY} !== {7'b1000000, 4'b1110, 1'b0}) begin
            errors++;
            $display("FAIL midreset got %b/%b/%b want 1000000/1110/0", SEG, an, BUSY);
        end
        #2;
        RESET_N = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if ({SEG, an, BUSY} !== {e_seg(), e_an(), e_busy()}) begin
                errors++;
                $display("FAIL after_midreset cyc %0d got %b/%b/%b want %b/%b/%b", i, SEG, an, BUSY, e_seg(), e_an(), e_busy());
            end
        end
    endtask

    task automatic test_ignore();
        wr(8'h81, 8'h09);
        wr(8'h40, 8'h55);
        checks++;
        if (BUSY !== 1'b0) begin errors++; $display("FAIL ignore_busy got %b want 0", BUSY); end
        wr(8'h82, 8'h00);
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if ({SEG, an, BUSY} !== {e_seg(), e_an(), e_busy()}) begin
                errors++;
                $display("FAIL ignore cyc %0d got %b/%b/%b want %b/%b/%b", i, SEG, an, BUSY, e_seg(), e_an(), e_busy());
            end
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 24);
            IO_STRB = 1'b0; PORT_ID = '0; OUT_PORT = '0;
            if (r < 3) begin
                IO_STRB = 1'b1; PORT_ID = 8'h81; OUT_PORT = 8'($urandom);
            end else if (r == 3) begin
                IO_STRB = 1'b1; PORT_ID = 8'h82;
                OUT_PORT = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 8'h27));
            end else if (r == 4) begin
                IO_STRB = 1'b1; PORT_ID = 8'($urandom); OUT_PORT = 8'($urandom);
            end else if (r == 5) begin
                PORT_ID = 8'h82; OUT_PORT = 8'($urandom);
            end
            tick();
            checks++;
            if ({SEG, an, BUSY} !== {e_seg(), e_an(), e_busy()}) begin
                errors++;
                $display("FAIL random cyc %0d disp %0d got %b/%b/%b want %b/%b/%b", i, m_disp, SEG, an, BUSY, e_seg(), e_an(), e_busy());
            end
        end
        IO_STRB = 1'b0; PORT_ID = '0; OUT_PORT = '0;
    endtask

    initial begin
        test_reset();
        test_1234();
        test_overflow();
        test_restart();
        test_reset_mid();
        test_ignore();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
